// File: rtl/trivium_decrypt.sv
// Trivium receive-side stream decryptor, 8 rounds per clock.
// Key/IV load, warm-up, then byte-wide XOR of ciphertext to plaintext.
module trivium_decrypt #(
  parameter int INIT_ROUNDS = 1152,
  parameter int LEN_W       = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [79:0]      key,
  input  logic [79:0]      iv,
  input  logic [LEN_W-1:0] len,
  input  logic             ct_valid,
  input  logic [7:0]       ct_data,
  output logic             ct_ready,
  output logic             pt_valid,
  output logic [7:0]       pt_data,
  input  logic             pt_ready,
  output logic             busy,
  output logic             done
);

  localparam int INIT_CYC = INIT_ROUNDS / 8;
  localparam int CW       = $clog2(INIT_CYC + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INIT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:288]     s_q, s_d, s_adv;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             pv_q, pv_d;
  logic [7:0]       pd_q, pd_d;
  logic [7:0]       ks;
  logic             accept;

  function automatic logic zbit(input logic [1:288] s);
    zbit = s[66] ^ s[93] ^ s[162] ^ s[177] ^ s[243] ^ s[288];
  endfunction

  function automatic logic [1:288] rnd(input logic [1:288] s);
    logic t1, t2, t3;
    t1  = s[66]  ^ s[93]  ^ (s[91]  & s[92])  ^ s[171];
    t2  = s[162] ^ s[177] ^ (s[175] & s[176]) ^ s[264];
    t3  = s[243] ^ s[288] ^ (s[286] & s[287]) ^ s[69];
    rnd = {t3, s[1:92], t1, s[94:176], t2, s[178:287]};
  endfunction

  // First keystream bit of the eight rounds lands in the byte MSB.
  always_comb begin
    ks    = '0;
    s_adv = s_q;
    for (int i = 0; i < 8; i++) begin
      ks[7-i] = zbit(s_adv);
      s_adv   = rnd(s_adv);
    end
  end

  assign ct_ready = (state_q == S_RUN) & (~pv_q | pt_ready)
                  & (rem_q != '0);
  assign accept   = ct_valid & ct_ready;
  assign pt_valid = pv_q;
  assign pt_data  = pd_q;
  assign busy     = (state_q == S_INIT) | (state_q == S_RUN);
  assign done     = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    pv_d    = pv_q;
    pd_d    = pd_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          s_d     = {key, 13'b0, iv, 4'b0, 108'b0, 3'b111};
          rem_d   = len & ~LEN_W'(7);
          cnt_d   = '0;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        s_d   = s_adv;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(INIT_CYC - 1)) begin
          state_d = (rem_q == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          pd_d  = ct_data ^ ks;
          pv_d  = 1'b1;
          s_d   = s_adv;
          rem_d = rem_q - LEN_W'(8);
        end else if (pt_ready) begin
          pv_d = 1'b0;
        end
        if (rem_q == '0 && (!pv_q || pt_ready)) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      pv_q    <= 1'b0;
      pd_q    <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      pv_q    <= pv_d;
      pd_q    <= pd_d;
    end
  end

endmodule

// File: tb/tb_trivium_decrypt.sv
// Testbench for trivium_decrypt: bit-serial Trivium model,
// vector table of messages plus reset/zero-length sequences.
`timescale 1ns/100ps
module tb_trivium_decrypt;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [79:0] key, iv;
  logic [11:0] len;
  logic        ct_valid;
  logic [7:0]  ct_data;
  logic        ct_ready;
  logic        pt_valid;
  logic [7:0]  pt_data;
  logic        pt_ready;
  logic        busy, done;

  trivium_decrypt dut (
    .clk(clk), .reset(reset), .start(start), .key(key), .iv(iv),
    .len(len), .ct_valid(ct_valid), .ct_data(ct_data),
    .ct_ready(ct_ready), .pt_valid(pt_valid), .pt_data(pt_data),
    .pt_ready(pt_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] key;
    logic [79:0] iv;
    logic [11:0] len;
    int          zero_ct;
    int          stall;
    int          seed;
  } vec_t;

  int checks = 0;
  int errors = 0;

  bit       m [1:288];
  bit [7:0] ks_exp [0:511];
  bit [7:0] pt_msg [0:511];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_step(output bit z);
    bit t1, t2, t3;
    t1 = m[66] ^ m[93];
    t2 = m[162] ^ m[177];
    t3 = m[243] ^ m[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (m[91] & m[92]) ^ m[171];
    t2 = t2 ^ (m[175] & m[176]) ^ m[264];
    t3 = t3 ^ (m[286] & m[287]) ^ m[69];
    for (int j = 288; j >= 2; j--) m[j] = m[j-1];
    m[1]   = t3;
    m[94]  = t1;
    m[178] = t2;
  endtask

  task automatic model_load(input logic [79:0] k, input logic [79:0] v,
                            input int nbytes);
    bit z;
    for (int i = 1; i <= 288; i++) m[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      m[i]      = k[80-i];
      m[93 + i] = v[80-i];
    end
    m[286] = 1'b1; m[287] = 1'b1; m[288] = 1'b1;
    repeat (1152) model_step(z);
    for (int b = 0; b < nbytes; b++) begin
      for (int i = 7; i >= 0; i--) begin
        model_step(z);
        ks_exp[b][i] = z;
      end
    end
  endtask

  task automatic run_msg(input logic [79:0] k, input logic [79:0] v,
                         input logic [11:0] l, input int zero_ct,
                         input int stall, input int seed,
                         input int stop_after);
    int n, cyc, sent, recv, t;
    bit held;
    logic [7:0] prev, expb;
    n = int'(l >> 3);
    model_load(k, v, n);
    for (int i = 0; i < n; i++) pt_msg[i] = 8'(i * 37 + seed);
    @(negedge clk);
    key = k; iv = v; len = l; start = 1'b1;
    ct_valid = 1'b1; ct_data = 8'h5A; pt_ready = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    chk("busy_rise", busy, 1);
    cyc = 0;
    while (!ct_ready && cyc < 400) begin
      cyc++;
      @(negedge clk); #1;
    end
    chk("init_cycles", cyc, 144);
    sent = 0; recv = 0; t = 0; held = 0; prev = '0;
    while ((recv < n || !done) && t < 3000) begin
      if (stop_after > 0 && recv >= stop_after) break;
      pt_ready = 1'b1;
      if (stall == 1 && t >= 8 && t < 18) pt_ready = 1'b0;
      if (stall == 2 && (t % 3) == 0) pt_ready = 1'b0;
      ct_valid = (sent < n);
      ct_data  = (sent < n && zero_ct == 0) ?
                 (pt_msg[sent] ^ ks_exp[sent]) : 8'h00;
      #1;
      if (held && pt_valid) chk("pt_stable", pt_data, prev);
      if (pt_valid && !pt_ready && ct_valid)
        chk("stall_ct_ready", ct_ready, 0);
      if (pt_valid && pt_ready) begin
        expb = zero_ct != 0 ? ks_exp[recv] : pt_msg[recv];
        if (recv < n) chk($sformatf("pt_byte%0d", recv), pt_data, expb);
        else chk("pt_extra", recv, n - 1);
        recv++;
      end
      held = pt_valid && !pt_ready;
      prev = pt_data;
      if (ct_valid && ct_ready) sent++;
      @(negedge clk); #1;
      t++;
    end
    ct_valid = 1'b0;
    if (stop_after == 0) begin
      chk("recv_count", recv, n);
      chk("done_high", done, 1);
      chk("busy_low", busy, 0);
      chk("pv_low", pt_valid, 0);
    end
  endtask

  vec_t vecs [4];
  int   k0;
  bit   seen_pv, seen_cr;

  initial begin
    vecs[0] = '{80'h0, 80'h8000_0000_0000_0000_0000, 12'd512, 0, 0, 3};
    vecs[1] = '{80'h0123_4567_89AB_CDEF_0123,
                80'hFEDC_BA98_7654_3210_FEDC, 12'd100, 1, 0, 0};
    vecs[2] = '{80'hDEAD_BEEF_0000_1111_2222,
                80'h0000_0000_0000_0000_0001, 12'd256, 0, 1, 11};
    vecs[3] = '{80'hFFFF_FFFF_FFFF_FFFF_FFFF,
                80'h1234_5678_9ABC_DEF0_1357, 12'd160, 1, 2, 0};

    reset = 1'b0; start = 1'b0; key = '0; iv = '0; len = '0;
    ct_valid = 1'b0; ct_data = '0; pt_ready = 1'b1;
    #3;
    chk("rst_ct_ready", ct_ready, 0);
    chk("rst_pt_valid", pt_valid, 0);
    chk("rst_pt_data", pt_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int v = 0; v < 4; v++)
      run_msg(vecs[v].key, vecs[v].iv, vecs[v].len, vecs[v].zero_ct,
              vecs[v].stall, vecs[v].seed, 0);

    // Zero-length message: start from DONE, INIT then straight to DONE.
    @(negedge clk);
    key = 80'h55; iv = 80'hAA; len = 12'd5; start = 1'b1;
    ct_valid = 1'b1; pt_ready = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    k0 = 1; seen_pv = 0; seen_cr = 0;
    while (!done && k0 < 400) begin
      if (pt_valid) seen_pv = 1;
      if (ct_ready) seen_cr = 1;
      @(negedge clk); #1;
      k0++;
    end
    chk("zl_done_cycle", k0, 145);
    chk("zl_pv_never", seen_pv, 0);
    chk("zl_cr_never", seen_cr, 0);
    ct_valid = 1'b0;

    // Abort mid-RUN with an off-edge reset pulse, then restart.
    run_msg(80'h0F0F_0F0F_0F0F_0F0F_0F0F,
            80'h3333_4444_5555_6666_7777, 12'd320, 1, 0, 0, 20);
    @(negedge clk); #2;
    reset = 1'b0;
    #0.5;
    chk("arst_ct_ready", ct_ready, 0);
    chk("arst_pt_valid", pt_valid, 0);
    chk("arst_pt_data", pt_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    #0.5;
    reset = 1'b1;
    run_msg(80'h0F0F_0F0F_0F0F_0F0F_0F0F,
            80'h3333_4444_5555_6666_7777, 12'd320, 1, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trivium_decrypt.md
Name: trivium_decrypt

Overview:
- Receive-side Trivium stream decryptor, the other end of the ENCRIPT keystream path.
- Loads an 80-bit key and 80-bit IV, runs the standard 1152-round warm-up, then XORs the keystream onto a byte stream of ciphertext.
- Ciphertext enters and plaintext leaves through valid/ready handshakes.
- The Trivium core is unrolled 8 rounds per clock, so the block sustains one byte per cycle.

Parameters:
- INIT_ROUNDS, 1152, warm-up rounds before output; must be a multiple of 8.
- LEN_W, 12, width of the message length (in bits).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches key/iv/len and begins init; honoured only in IDLE or DONE
- key  in  80  key; key[79] = K1
- iv  in  80  IV; iv[79] = IV1
- len  in  LEN_W  message length in bits; len[2:0] ignored; byte count = len>>3
- ct_valid  in  1  ciphertext byte valid
- ct_data  in  8  ciphertext byte
- ct_ready  out  1  block accepts ct_data this cycle
- pt_valid  out  1  plaintext byte valid
- pt_data  out  8  plaintext byte
- pt_ready  in  1  downstream accepts pt_data
- busy  out  1  high in INIT or RUN
- done  out  1  high in DONE

Behaviour:
- Reset (async assert, sync release): state = IDLE, 288-bit state cleared, counters 0. Outputs: ct_ready = 0, pt_valid = 0, pt_data = 0, busy = 0, done = 0.
- State load on start:
  - s1..s80 = key[79:0], s81..s93 = 0.
  - s94..s173 = iv[79:0], s174..s177 = 0.
  - s178..s285 = 0, s286..s288 = 1.
  - Remaining byte counter = len>>3.
- Round function is standard Trivium:
  - t1 = s66^s93, t2 = s162^s177, t3 = s243^s288.
  - z = t1^t2^t3.
  - Shift-in terms use s91&s92, s175&s176, s286&s287 with s171, s264, s69.
  - One clock = 8 chained rounds.
- States:
  - IDLE: waits for start, then goes to INIT.
  - INIT: runs INIT_ROUNDS/8 cycles (144 by default) with a cycle counter; keystream is discarded. Moves to RUN, or directly to DONE if byte count = 0.
  - RUN:
    - ct_ready = (!pt_valid | pt_ready) & (remaining != 0).
    - On ct_valid & ct_ready: pt_data <= ct_data ^ {z1..z8}. z1 (first keystream bit of the 8 rounds) XORs bit 7 (MSB-first). pt_valid <= 1, state advances 8 rounds, remaining decrements.
    - The state advances only on an accepted byte; a stall freezes keystream position.
    - After the last byte is accepted and pt_valid clears (pt_ready seen), go to DONE.
  - DONE: done = 1. Start re-enters INIT with new key/iv/len; start in any other state is ignored.
- Latency and throughput: plaintext appears 1 cycle after acceptance. Full throughput is 1 byte/cycle when pt_ready is held high.
- pt_valid handshake: pt_valid stays high, with pt_data stable, until pt_ready. pt_valid <= 0 on pt_ready with no new accept.
- Simultaneous accept and drain in the same cycle loads the new byte; there is no bubble.
- Reset mid-operation aborts immediately to IDLE. Any pending plaintext is dropped.
- ct_valid outside RUN is ignored (ct_ready = 0).
- len < 8 gives byte count 0: after INIT go straight to DONE, pt_valid never asserted.

Test Plan:
- Round trip: key = 80'h0, iv = 80'h80000000000000000000, len = 512. Feed the 64-byte ENCRIPT output for the same key/iv and a known plaintext, MSB-first bytes. Required: pt_data matches the plaintext byte-for-byte, and done rises after 64 outputs.
- Init timing: start pulse. Required: busy rises next cycle, ct_ready = 0 for exactly 144 cycles, then ct_ready = 1. Zero ciphertext: pt_data equals keystream bytes from a reference model.
- Backpressure: hold pt_ready = 0 for 10 cycles mid-stream with ct_valid = 1. Required: ct_ready = 0, pt_data stable, and no keystream skipped (output still matches the model).
- Zero-length message: len = 12'd5. Required: DONE reached 145 cycles after start; pt_valid never high; ct_ready never high.
- Async reset mid-RUN: after 20 bytes assert reset for 1 ns off-edge. Required: all outputs 0 immediately. A restart with the same key/iv reproduces byte 0.
- Restart from DONE: a start pulse with a new key produces the new keystream; ct_valid ignored during INIT.
